inv_mix_cols_seq: RTL and testbench



---
 rtl/inv_mix_pkg.sv | 24 ++
 rtl/reverse_mix_cols.sv | 40 ++++
 rtl/inv_mix_cols_seq.sv | 108 ++++++++++
 tb/tb_inv_mix_cols_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_mix_pkg.sv
// Shared types and GF(2^8) helper for the inverse MixColumns sequencer.
// Optional bypass feature is controlled by INV_MIX_SKIP_EN.
package inv_mix_pkg;

  localparam int NCOLS = 4;
  localparam int COL_W = 32;

  typedef logic [COL_W-1:0] col_t;
  typedef logic [NCOLS-1:0][COL_W-1:0] state_t;
  typedef logic [1:0] col_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } inv_mix_st_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/reverse_mix_cols.sv
// Combinational AES inverse MixColumns on a single 32-bit column.
// Byte 0 of the column sits in bits [31:24].
module reverse_mix_cols
  import inv_mix_pkg::*;
(
  input  col_t input_col,
  output col_t final_col
);

  logic [7:0] a   [4];
  logic [7:0] x2  [4];
  logic [7:0] x4  [4];
  logic [7:0] x8  [4];
  logic [7:0] m9  [4];
  logic [7:0] m11 [4];
  logic [7:0] m13 [4];
  logic [7:0] m14 [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]   = input_col[31-8*i -: 8];
      x2[i]  = xtime(a[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m9[i]  = x8[i] ^ a[i];
      m11[i] = x8[i] ^ x2[i] ^ a[i];
      m13[i] = x8[i] ^ x4[i] ^ a[i];
      m14[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  // Rows of the circulant matrix {0e,0b,0d,09}
  assign final_col = {
    m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
    m14[1] ^ m11[2] ^ m13[3] ^ m9[0],
    m14[2] ^ m11[3] ^ m13[0] ^ m9[1],
    m14[3] ^ m11[0] ^ m13[1] ^ m9[2]
  };

endmodule

// File: rtl/inv_mix_cols_seq.sv
// Inverse MixColumns over a 128-bit state, one column per cycle.
// Define INV_MIX_SKIP_EN to add the in_skip bypass port.
module inv_mix_cols_seq
  import inv_mix_pkg::*;
#(
  parameter int NCOLS = inv_mix_pkg::NCOLS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef INV_MIX_SKIP_EN
  input  logic         in_skip,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam col_idx_t LAST = col_idx_t'(NCOLS - 1);

  inv_mix_st_e st_q;
  col_idx_t    col_q;
  state_t      src_q;
  state_t      dst_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  col_idx_t    sel;
  col_t        mix_in;
  col_t        mix_out;

  // Column 0 lives in the top word of the packed state
  assign sel    = LAST - col_q;
  assign mix_in = src_q[sel];

  reverse_mix_cols u_mix (
    .input_col (mix_in),
    .final_col (mix_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      col_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef INV_MIX_SKIP_EN
            if (in_skip) begin
              dst_q       <= in_state;
              out_valid_q <= 1'b1;
              st_q        <= DONE;
            end else begin
              src_q <= in_state;
              col_q <= '0;
              st_q  <= RUN;
            end
`else
            src_q <= in_state;
            col_q <= '0;
            st_q  <= RUN;
`endif
          end
        end
        RUN: begin
          dst_q[sel] <= mix_out;
          col_q      <= col_q + col_idx_t'(1);
          if (col_q == LAST) begin
            st_q        <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q        <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          st_q        <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = dst_q;

endmodule

// File: tb/tb_inv_mix_cols_seq.sv
// Self-checking bench for inv_mix_cols_seq against a matrix-level
// GF(2^8) reference model; covers INV_MIX_SKIP_EN when defined.
module tb_inv_mix_cols_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
`ifdef INV_MIX_SKIP_EN
  logic         in_skip = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

  int checks = 0;
  int errors = 0;

  inv_mix_cols_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef INV_MIX_SKIP_EN
    .in_skip   (in_skip),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(
    input logic [127:0] s
  );
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   b;
    coef[0] = 8'h0e;
    coef[1] = 8'h0b;
    coef[2] = 8'h0d;
    coef[3] = 8'h09;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++)
        a[j] = s[127-32*c-8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        b = '0;
        for (int j = 0; j < 4; j++)
          b = b ^ gmul(a[j], coef[(j - row) & 3]);
        r[127-32*c-8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s, output bit ok);
    int n;
    n = 0;
    in_state = s;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (out_state !== 128'h0) begin
      errors++;
      $display("FAIL rst_out_state got %h want 0", out_state);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_known();
    logic [127:0] vin  [2];
    logic [127:0] vexp [2];
    bit ok;
    int lat;
    vin[0]  = 128'h416e1899_e0958b65_416e1899_e0958b65;
    vexp[0] = 128'hc9dad76a_926bd4b6_c9dad76a_926bd4b6;
    vin[1]  = 128'h8e4da1bc_9fdc589d_01010101_00000000;
    vexp[1] = 128'hdb135345_f20a225c_01010101_00000000;
    out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      send(vin[v], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL known%0d_accept got 0 want 1", v);
      end
      wait_valid(lat);
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL known%0d_latency got %0d want 4", v, lat);
      end
      checks++;
      if (out_state !== vexp[v]) begin
        errors++;
        $display("FAIL known%0d_const got %h want %h",
                 v, out_state, vexp[v]);
      end
      checks++;
      if (out_state !== model(vin[v])) begin
        errors++;
        $display("FAIL known%0d_model got %h want %h",
                 v, out_state, model(vin[v]));
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL known%0d_pulse got v=%b r=%b want v=0 r=1",
                 v, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s;
    logic [127:0] hold;
    bit ok;
    int lat;
    s = rnd128();
    out_ready = 1'b0;
    send(s, ok);
    wait_valid(lat);
    hold = out_state;
    checks++;
    if (!out_valid || hold !== model(s)) begin
      errors++;
      $display("FAIL bp_result got v=%b %h want v=1 %h",
               out_valid, hold, model(s));
    end
    for (int i = 0; i < 6; i++) begin
      in_state = ~s;
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_state !== hold) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b r=%b %h want v=1 r=0 %h",
                 i, out_valid, in_ready, out_state, hold);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got v=%b r=%b b=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_not_queued got busy=%b want 0", busy);
    end
  endtask

  task automatic test_ignore_in_run();
    logic [127:0] a;
    logic [127:0] b;
    bit ok;
    int lat;
    a = rnd128();
    b = rnd128();
    out_ready = 1'b1;
    send(a, ok);
    in_state = b;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat + 2 != 4 || out_state !== model(a)) begin
      errors++;
      $display("FAIL run_ignore got lat=%0d %h want lat=4 %h",
               lat + 2, out_state, model(a));
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_not_queued got b=%b v=%b want 0 0",
               busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] a;
    logic [127:0] b;
    bit ok;
    int lat;
    a = rnd128();
    b = rnd128();
    out_ready = 1'b1;
    send(a, ok);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_state !== 128'h0) begin
      errors++;
      $display("FAIL async_rst got r=%b v=%b b=%b %h want 1 0 0 0",
               in_ready, out_valid, busy, out_state);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send(b, ok);
    wait_valid(lat);
    checks++;
    if (lat != 4 || out_state !== model(b)) begin
      errors++;
      $display("FAIL post_rst got lat=%0d %h want lat=4 %h",
               lat, out_state, model(b));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic [127:0] stim [N];
    logic [127:0] exp_q [$];
    logic [127:0] got;
    logic [127:0] want;
    int issued;
    int received;
    int cycles;
    bit acc;
    bit hsk;
    for (int i = 0; i < N; i++) stim[i] = rnd128();
    issued = 0;
    received = 0;
    cycles = 0;
    out_ready = 1'b1;
    while (received < N && cycles < 200) begin
      in_valid = (issued < N);
      in_state = stim[issued < N ? issued : 0];
      acc = in_valid && in_ready;
      hsk = out_valid && out_ready;
      got = out_state;
      tick();
      cycles++;
      if (acc) begin
        exp_q.push_back(model(stim[issued]));
        issued++;
      end
      if (hsk) begin
        want = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b_%0d got %h want %h", received, got, want);
        end
        received++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (received != N || cycles > 6 * N + 4) begin
      errors++;
      $display("FAIL b2b_throughput got %0d in %0d cycles want %0d",
               received, cycles, N);
    end
  endtask

`ifdef INV_MIX_SKIP_EN
  task automatic test_skip();
    logic [127:0] s;
    bit ok;
    s = 128'h416e1899_e0958b65_00000000_01010101;
    out_ready = 1'b1;
    in_skip = 1'b1;
    send(s, ok);
    in_skip = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_state !== s) begin
      errors++;
      $display("FAIL skip_out got v=%b %h want v=1 %h",
               out_valid, out_state, s);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skip_done got v=%b r=%b want 0 1",
               out_valid, in_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_known();
    test_backpressure();
    test_ignore_in_run();
    test_reset_mid_run();
    test_back_to_back();
`ifdef INV_MIX_SKIP_EN
    test_skip();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
